// File: rtl/divn_check.sv
// Sequential divisibility checker: restoring division, one quotient bit per clock.
// Optional power-of-two fast path enabled by defining DIVN_POW2_FAST_EN.
module divn_check #(
   parameter int WIDTH  = 8,
   parameter int DWIDTH = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  data,
   input  logic [DWIDTH-1:0] divisor,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  quotient,
   output logic [DWIDTH-1:0] remainder,
   output logic              divisible,
   output logic              odd,
   output logic              div_by_zero
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam int CW = $clog2(WIDTH);

   logic [1:0]        state;
   logic [CW-1:0]     cnt;
   logic [WIDTH-1:0]  w;
   logic [DWIDTH-1:0] r;
   logic [DWIDTH-1:0] dvs;
   logic              zdiv;

   logic [DWIDTH:0]   r_sh;
   logic              ge;
   logic [DWIDTH-1:0] r_nx;
   logic [WIDTH-1:0]  q_nx;
   logic [WIDTH-1:0]  res_q;
   logic [DWIDTH-1:0] res_r;
   logic              short_in;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   // w starts as the dividend and fills with quotient bits from the right
   always_comb begin
      r_sh = {r, w[WIDTH-1]};
      ge   = (r_sh >= {1'b0, dvs});
      r_nx = ge ? DWIDTH'(r_sh - {1'b0, dvs}) : r_sh[DWIDTH-1:0];
      q_nx = {w[WIDTH-2:0], ge};
   end

`ifdef DIVN_POW2_FAST_EN
   localparam int SW = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;

   logic          fast;
   logic          p2_in;
   logic [SW-1:0] sh;

   assign p2_in = (divisor != '0) &&
                  ((divisor & (divisor - DWIDTH'(1))) == '0);

   always_comb begin
      sh = '0;
      for (int i = 0; i < DWIDTH; i++)
         if (dvs[i]) sh = SW'(i);
   end

   assign short_in = (divisor == '0) || p2_in;
`else
   assign short_in = (divisor == '0);
`endif

   // Short paths finish on the first BUSY edge while w still holds the dividend
   always_comb begin
      res_q = q_nx;
      res_r = r_nx;
      if (zdiv) begin
         res_q = '1;
         res_r = w[DWIDTH-1:0];
      end
`ifdef DIVN_POW2_FAST_EN
      else if (fast) begin
         res_q = w >> sh;
         res_r = w[DWIDTH-1:0] & (dvs - DWIDTH'(1));
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         w           <= '0;
         r           <= '0;
         dvs         <= '0;
         zdiv        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         divisible   <= 1'b0;
         odd         <= 1'b0;
         div_by_zero <= 1'b0;
`ifdef DIVN_POW2_FAST_EN
         fast        <= 1'b0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  w     <= data;
                  dvs   <= divisor;
                  r     <= '0;
                  odd   <= data[0];
                  zdiv  <= (divisor == '0);
`ifdef DIVN_POW2_FAST_EN
                  fast  <= p2_in;
`endif
                  cnt   <= short_in ? '0 : CW'(WIDTH - 1);
                  state <= BUSY;
               end
            end
            BUSY: begin
               w   <= q_nx;
               r   <= r_nx;
               cnt <= cnt - CW'(1);
               if (cnt == '0) begin
                  quotient    <= res_q;
                  remainder   <= res_r;
                  divisible   <= (res_r == '0) && !zdiv;
                  div_by_zero <= zdiv;
                  state       <= DONE;
               end
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_divn_check.sv
// Directed bench for divn_check: vector table plus back-pressure,
// mid-operation reset and a 16-bit instance.
module tb_divn_check;

   logic        clk = 1'b0;
   logic        rst;

   logic        in_valid, in_ready, out_valid, out_ready;
   logic [7:0]  data, divisor, quotient, remainder;
   logic        divisible, odd, div_by_zero;

   logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic [15:0] b_data, b_quotient;
   logic [7:0]  b_divisor, b_remainder;
   logic        b_divisible, b_odd, b_div_by_zero;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   divn_check #(.WIDTH(8), .DWIDTH(8)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .data(data), .divisor(divisor),
      .out_valid(out_valid), .out_ready(out_ready),
      .quotient(quotient), .remainder(remainder),
      .divisible(divisible), .odd(odd), .div_by_zero(div_by_zero)
   );

   divn_check #(.WIDTH(16), .DWIDTH(8)) dut16 (
      .clk(clk), .rst(rst),
      .in_valid(b_in_valid), .in_ready(b_in_ready),
      .data(b_data), .divisor(b_divisor),
      .out_valid(b_out_valid), .out_ready(b_out_ready),
      .quotient(b_quotient), .remainder(b_remainder),
      .divisible(b_divisible), .odd(b_odd), .div_by_zero(b_div_by_zero)
   );

   typedef struct {
      logic [7:0] d;
      logic [7:0] v;
      logic [7:0] q;
      logic [7:0] r;
      logic       dv;
      logic       od;
      logic       dz;
   } vec_t;

   vec_t tv[12];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic bit is_p2(input logic [7:0] v);
      return (v != 0) && ((v & (v - 8'd1)) == 0);
   endfunction

   function automatic int exp_lat(input logic [7:0] v);
      if (v == 0) return 1;
`ifdef DIVN_POW2_FAST_EN
      if (is_p2(v)) return 1;
`endif
      return 8;
   endfunction

   // Present one request; return edges from acceptance to out_valid
   task automatic req(input logic [7:0] d, input logic [7:0] v,
                      output int lat);
      int n;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      in_valid = 1'b1;
      data     = d;
      divisor  = v;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      data     = 8'($urandom);
      divisor  = 8'($urandom);
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic release_out();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   initial begin
      int lat;
      int seen;

      tv[0]  = '{8'd255, 8'd2,   8'd127, 8'd1,  1'b0, 1'b1, 1'b0};
      tv[1]  = '{8'd64,  8'd8,   8'd8,   8'd0,  1'b1, 1'b0, 1'b0};
      tv[2]  = '{8'd6,   8'd0,   8'hFF,  8'd6,  1'b0, 1'b0, 1'b1};
      tv[3]  = '{8'd15,  8'd4,   8'd3,   8'd3,  1'b0, 1'b1, 1'b0};
      tv[4]  = '{8'd0,   8'd7,   8'd0,   8'd0,  1'b1, 1'b0, 1'b0};
      tv[5]  = '{8'd200, 8'd1,   8'd200, 8'd0,  1'b1, 1'b0, 1'b0};
      tv[6]  = '{8'd3,   8'd10,  8'd0,   8'd3,  1'b0, 1'b1, 1'b0};
      tv[7]  = '{8'd100, 8'd7,   8'd14,  8'd2,  1'b0, 1'b0, 1'b0};
      tv[8]  = '{8'd250, 8'd25,  8'd10,  8'd0,  1'b1, 1'b0, 1'b0};
      tv[9]  = '{8'd255, 8'd255, 8'd1,   8'd0,  1'b1, 1'b1, 1'b0};
      tv[10] = '{8'd17,  8'd0,   8'hFF,  8'd17, 1'b0, 1'b1, 1'b1};
      tv[11] = '{8'd128, 8'd16,  8'd8,   8'd0,  1'b1, 1'b0, 1'b0};

      rst = 1'b1;
      in_valid = 1'b0; data = '0; divisor = '0; out_ready = 1'b0;
      b_in_valid = 1'b0; b_data = '0; b_divisor = '0; b_out_ready = 1'b0;
      #1;
      chk("rst in_ready", in_ready, 1);
      chk("rst out_valid", out_valid, 0);
      chk("rst quotient", quotient, 0);
      chk("rst remainder", remainder, 0);
      chk("rst divisible", divisible, 0);
      chk("rst odd", odd, 0);
      chk("rst div_by_zero", div_by_zero, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 12; i++) begin
         req(tv[i].d, tv[i].v, lat);
         chk($sformatf("v%0d latency", i), lat, exp_lat(tv[i].v));
         chk($sformatf("v%0d quotient", i), quotient, tv[i].q);
         chk($sformatf("v%0d remainder", i), remainder, tv[i].r);
         chk($sformatf("v%0d divisible", i), divisible, tv[i].dv);
         chk($sformatf("v%0d odd", i), odd, tv[i].od);
         chk($sformatf("v%0d div_by_zero", i), div_by_zero, tv[i].dz);
         chk($sformatf("v%0d in_ready done", i), in_ready, 0);
         release_out();
         chk($sformatf("v%0d in_ready after", i), in_ready, 1);
         chk($sformatf("v%0d out_valid after", i), out_valid, 0);
      end

      // Back-pressure on 15/4 while a new request waits in DONE
      req(8'd15, 8'd4, lat);
      chk("bp latency", lat, exp_lat(8'd4));
      @(negedge clk);
      in_valid = 1'b1; data = 8'd99; divisor = 8'd3;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         chk($sformatf("bp%0d out_valid", c), out_valid, 1);
         chk($sformatf("bp%0d quotient", c), quotient, 3);
         chk($sformatf("bp%0d remainder", c), remainder, 3);
         chk($sformatf("bp%0d in_ready", c), in_ready, 0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("bp idle in_ready", in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0; data = 8'd0; divisor = 8'd0;
      chk("bp queued accepted", in_ready, 0);
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk("bp2 latency", lat, 8);
      chk("bp2 quotient", quotient, 33);
      chk("bp2 remainder", remainder, 0);
      chk("bp2 divisible", divisible, 1);
      release_out();

      // Reset during BUSY discards the request
      @(negedge clk);
      in_valid = 1'b1; data = 8'd127; divisor = 8'd5;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("mid rst in_ready", in_ready, 1);
      chk("mid rst out_valid", out_valid, 0);
      chk("mid rst quotient", quotient, 0);
      chk("mid rst remainder", remainder, 0);
      chk("mid rst odd", odd, 0);
      chk("mid rst divisible", divisible, 0);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk);
         #1;
         if (out_valid) seen++;
      end
      chk("mid rst no out_valid", seen, 0);
      req(8'd0, 8'd7, lat);
      chk("post rst latency", lat, 8);
      chk("post rst quotient", quotient, 0);
      chk("post rst remainder", remainder, 0);
      chk("post rst divisible", divisible, 1);
      release_out();

      // 16-bit dividend, 8-bit divisor
      @(negedge clk);
      b_in_valid = 1'b1; b_data = 16'd1000; b_divisor = 8'd7;
      @(posedge clk);
      #1;
      b_in_valid = 1'b0; b_data = 16'hFFFF; b_divisor = 8'd1;
      lat = 0;
      while (!b_out_valid && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk("w16 latency", lat, 16);
      chk("w16 quotient", b_quotient, 142);
      chk("w16 remainder", b_remainder, 6);
      chk("w16 divisible", b_divisible, 0);
      chk("w16 odd", b_odd, 0);
      chk("w16 div_by_zero", b_div_by_zero, 0);
      @(negedge clk);
      b_out_ready = 1'b1;
      @(posedge clk);
      #1;
      b_out_ready = 1'b0;
      chk("w16 in_ready after", b_in_ready, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
